// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers the fetched instruction and its npc, and
// produces the execute/writeback/memory control words for that instruction.
module lc3_decode #(
   parameter logic [15:0] IR_RESET = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_decode,
   input  logic [15:0] dout,
   input  logic [15:0] npc_in,
   output logic [15:0] IR,
   output logic [15:0] npc_out,
   output logic [5:0]  E_Control,
   output logic [1:0]  W_Control,
   output logic        Mem_Control,
   output logic        illegal_op
);

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_AND = 2'b01;
   localparam logic [1:0] ALU_NOT = 2'b10;

   localparam logic [1:0] PC1_ZERO = 2'b00;
   localparam logic [1:0] PC1_OFF6 = 2'b01;
   localparam logic [1:0] PC1_OFF9 = 2'b10;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   logic [3:0]  opcode;
   logic [1:0]  alu_control_next;
   logic [1:0]  pcselect1_next;
   logic        pcselect2_next;
   logic        op2select_next;
   logic [1:0]  w_control_next;
   logic        mem_control_next;
   logic        illegal_next;

   logic [15:0] ir_reg;
   logic [15:0] npc_reg;
   logic [5:0]  e_control_reg;
   logic [1:0]  w_control_reg;
   logic        mem_control_reg;
   logic        illegal_reg;

   assign opcode = dout[15:12];

   // Control is decoded from the incoming word so it lands in the same edge as IR.
   always_comb begin
      alu_control_next = ALU_ADD;
      pcselect1_next   = PC1_ZERO;
      pcselect2_next   = 1'b0;
      op2select_next   = 1'b0;
      w_control_next   = WB_ALU;
      mem_control_next = 1'b0;
      illegal_next     = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_control_next = ALU_ADD;
            op2select_next   = ~dout[5];
         end
         OP_AND: begin
            alu_control_next = ALU_AND;
            op2select_next   = ~dout[5];
         end
         OP_NOT: begin
            alu_control_next = ALU_NOT;
         end
         OP_BR: begin
            pcselect1_next = PC1_OFF9;
            pcselect2_next = 1'b1;
         end
         OP_JMP: begin
            pcselect1_next = PC1_ZERO;
            pcselect2_next = 1'b0;
         end
         OP_LD: begin
            pcselect1_next = PC1_OFF9;
            pcselect2_next = 1'b1;
            w_control_next = WB_MEM;
         end
         OP_LDR: begin
            pcselect1_next = PC1_OFF6;
            pcselect2_next = 1'b0;
            w_control_next = WB_MEM;
         end
         OP_LDI: begin
            pcselect1_next   = PC1_OFF9;
            pcselect2_next   = 1'b1;
            w_control_next   = WB_MEM;
            mem_control_next = 1'b1;
         end
         OP_LEA: begin
            pcselect1_next = PC1_OFF9;
            pcselect2_next = 1'b1;
            w_control_next = WB_PC;
         end
         OP_ST: begin
            pcselect1_next = PC1_OFF9;
            pcselect2_next = 1'b1;
         end
         OP_STR: begin
            pcselect1_next = PC1_OFF6;
            pcselect2_next = 1'b0;
         end
         OP_STI: begin
            pcselect1_next   = PC1_OFF9;
            pcselect2_next   = 1'b1;
            mem_control_next = 1'b1;
         end
         default: begin
            illegal_next = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir_reg          <= IR_RESET;
         npc_reg         <= 16'h0000;
         e_control_reg   <= 6'b000000;
         w_control_reg   <= WB_ALU;
         mem_control_reg <= 1'b0;
         illegal_reg     <= 1'b0;
      end else if (enable_decode) begin
         ir_reg          <= dout;
         npc_reg         <= npc_in;
         e_control_reg   <= {alu_control_next, pcselect1_next, pcselect2_next, op2select_next};
         w_control_reg   <= w_control_next;
         mem_control_reg <= mem_control_next;
         illegal_reg     <= illegal_next;
      end
   end

   assign IR          = ir_reg;
   assign npc_out     = npc_reg;
   assign E_Control   = e_control_reg;
   assign W_Control   = w_control_reg;
   assign Mem_Control = mem_control_reg;
   assign illegal_op  = illegal_reg;

endmodule

// File: doc/lc3_decode.md
# lc3_decode

Decode stage of the LC-3 pipeline, directly downstream of fetch. It consumes the instruction word returned from instruction memory (`dout`) and the fetch stage's `npc`. It registers both and produces the execute, writeback and memory control words for the execute stage. One-cycle latency, gated by the controller's `enable_decode`.

## Interface
- `IR_RESET`, default 16'h0000: value loaded into `IR` on reset.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; has priority over `enable_decode`.
- `enable_decode` input 1: when high, sample `dout`/`npc_in` and update all outputs.
- `dout` input 16: instruction word from instruction memory.
- `npc_in` input 16: PC+1 from the fetch stage (its `npc` output).
- `IR` output 16: registered instruction.
- `npc_out` output 16: registered `npc_in`.
- `E_Control` output 6: {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `W_Control` output 2: writeback select. 0 = ALU result, 1 = memory data, 2 = PC/address result, 3 = never generated.
- `Mem_Control` output 1: 1 = indirect access (LDI/STI), 0 otherwise.
- `illegal_op` output 1: 1 when the registered opcode is unsupported.

## Operation
- Field encodings:
  - alu_control: 00 ADD, 01 AND, 10 NOT.
  - pcselect1: 00 zero, 01 sext(IR[5:0]), 10 sext(IR[8:0]), 11 reserved (never generated).
  - pcselect2: 1 = npc base, 0 = register base.
  - op2select: 1 = register operand, 0 = sext(IR[4:0]).
- Any field not used by an opcode is driven 0.
- Decode on opcode `dout[15:12]`:
  - ADD 0001: alu 00; op2select = ~dout[5]; W 0.
  - AND 0101: alu 01; op2select = ~dout[5]; W 0.
  - NOT 1001: alu 10; W 0.
  - BR 0000: pcsel1 10; pcsel2 1; W 0.
  - JMP 1100: pcsel1 00; pcsel2 0; W 0.
  - LD 0010: pcsel1 10; pcsel2 1; W 1; Mem 0.
  - LDR 0110: pcsel1 01; pcsel2 0; W 1; Mem 0.
  - LDI 1010: pcsel1 10; pcsel2 1; W 1; Mem 1.
  - LEA 1110: pcsel1 10; pcsel2 1; W 2.
  - ST 0011: pcsel1 10; pcsel2 1; W 0; Mem 0.
  - STR 0111: pcsel1 01; pcsel2 0; W 0; Mem 0.
  - STI 1011: pcsel1 10; pcsel2 1; W 0; Mem 1.
  - 0100, 1000, 1101, 1111: all control fields 0; `illegal_op` 1.
- `IR` and `npc_out` are loaded unmodified, including for illegal opcodes.
- Control words are computed from `dout` combinationally and registered with `IR`. They always correspond to the current `IR`, never lag it.

## Timing
- Reset: on any edge with `reset`=1, the outputs take these values regardless of `enable_decode`:
  - `IR`=IR_RESET.
  - `npc_out`, `E_Control`, `W_Control`, `Mem_Control` = 0.
  - `illegal_op` = 0.
- Load: on an edge with `reset`=0 and `enable_decode`=1, all outputs update together. Latency is 1 cycle from `dout`/`npc_in` valid.
- Hold: `enable_decode`=0 keeps every output at its previous value, for any number of cycles, whatever `dout`/`npc_in` do.
- Back-to-back: `enable_decode` high on consecutive edges decodes one instruction per cycle, with no bubble.
- Reset asserted mid-stream discards the in-flight instruction. The first decode after reset deasserts occurs on the first edge with `enable_decode`=1.
- No combinational path from inputs to outputs.

## Test plan
- Reset: `reset`=1 for 2 cycles, `enable_decode`=1, `dout`=16'h1234, `npc_in`=16'h3000 -> `IR`=16'h0000, `npc_out`=0, `E_Control`=0, `W_Control`=0, `Mem_Control`=0, `illegal_op`=0.
- ALU ops:
  - `dout`=16'h1042, `npc_in`=16'h3001, enabled -> next edge `IR`=16'h1042, `npc_out`=16'h3001, `E_Control`=6'b000001, `W_Control`=0.
  - `dout`=16'h1061 -> `E_Control`=6'b000000.
  - `dout`=16'h903F -> `E_Control`=6'b100000.
- Memory ops:
  - `dout`=16'hA005 (LDI) -> `E_Control`=6'b001010, `W_Control`=1, `Mem_Control`=1.
  - `dout`=16'h6283 (LDR) -> `E_Control`=6'b000100, `W_Control`=1, `Mem_Control`=0.
  - `dout`=16'hE1FF (LEA) -> `E_Control`=6'b001010, `W_Control`=2.
- Hold: after decoding 16'h5042, set `enable_decode`=0 for 3 cycles while `dout`=16'hC1C0 and `npc_in` changes -> `IR` stays 16'h5042 and `E_Control` stays 6'b010001.
- Illegal opcode: `dout`=16'hD000 -> `IR`=16'hD000, all control fields 0, `illegal_op`=1. Next enabled 16'h0E02 (BR) -> `illegal_op`=0, `E_Control`=6'b001010.
- Reset mid-stream: decode 16'h3005 (ST), then assert `reset` together with `enable_decode` and `dout`=16'h1042 -> all outputs return to reset values on that edge.
